// File: rtl/cfg_bank_pkg.sv
// Shared definitions for the configuration bank writer: FSM encoding and
// the counter width helper used to size the row, bit and pulse counters.
package cfg_bank_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SHIFT = 3'd1,
      ST_SETUP = 3'd2,
      ST_PULSE = 3'd3,
      ST_HOLD  = 3'd4,
      ST_DONE  = 3'd5
   } cb_state_e;

   // Never returns less than 1 so a counter for a single value still has a bit.
   function automatic int cb_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/cfg_bank_shift_reg.sv
// Serial-to-parallel shadow register; bits enter at the MSB so that after a
// full row the first bit received sits in bit 0.
module cfg_bank_shift_reg #(
   parameter int BL_WIDTH = 8
) (
   input  logic                prog_clk,
   input  logic                prog_reset_n,
   input  logic                shift_en,
   input  logic                clear,
   input  logic                din,
   output logic [BL_WIDTH-1:0] q
);

   logic [BL_WIDTH-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (clear)         q_d = '0;
      else if (shift_en) q_d = {din, q_q[BL_WIDTH-1:1]};
   end

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) q_q <= '0;
      else               q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/cfg_bank_writer.sv
// Programs a BL_WIDTH x WL_WIDTH configuration bank from a serial stream:
// shift a row in, then drive bitlines around a WL_PULSE-cycle wordline pulse.
module cfg_bank_writer
   import cfg_bank_pkg::*;
#(
   parameter int BL_WIDTH = 8,
   parameter int WL_WIDTH = 4,
   parameter int WL_PULSE = 2
) (
   input  logic                prog_clk,
   input  logic                prog_reset_n,
   input  logic                start,
   input  logic                abort,
   input  logic                cfg_din,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   output logic [BL_WIDTH-1:0] bl,
   output logic [WL_WIDTH-1:0] wl,
   output logic                busy,
   output logic                done
);

   localparam int RW = cb_clog2(WL_WIDTH);
   localparam int BW = cb_clog2(BL_WIDTH);
   localparam int PW = cb_clog2(WL_PULSE);

   cb_state_e           state_q, state_d;
   logic [RW-1:0]       row_q, row_d;
   logic [BW-1:0]       bit_q, bit_d;
   logic [PW-1:0]       pcnt_q, pcnt_d;
   logic [BL_WIDTH-1:0] bl_q, bl_d;
   logic [WL_WIDTH-1:0] wl_q, wl_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                xfer, sr_clear;
   logic [BL_WIDTH-1:0] shadow, shadow_nxt;

   assign cfg_ready  = (state_q == ST_SHIFT) && !abort;
   assign xfer       = cfg_valid && cfg_ready;
   assign shadow_nxt = {cfg_din, shadow[BL_WIDTH-1:1]};

   cfg_bank_shift_reg #(.BL_WIDTH(BL_WIDTH)) u_shadow (
      .prog_clk     (prog_clk),
      .prog_reset_n (prog_reset_n),
      .shift_en     (xfer),
      .clear        (sr_clear),
      .din          (cfg_din),
      .q            (shadow)
   );

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      bit_d    = bit_q;
      pcnt_d   = pcnt_q;
      sr_clear = 1'b0;
      if (abort) begin
         state_d  = ST_IDLE;
         row_d    = '0;
         bit_d    = '0;
         pcnt_d   = '0;
         sr_clear = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: if (start) begin
               state_d  = ST_SHIFT;
               row_d    = '0;
               bit_d    = '0;
               sr_clear = 1'b1;
            end
            ST_SHIFT: if (xfer) begin
               if (bit_q == BW'(BL_WIDTH - 1)) state_d = ST_SETUP;
               else                            bit_d   = bit_q + 1'b1;
            end
            ST_SETUP: begin
               state_d = ST_PULSE;
               pcnt_d  = '0;
            end
            ST_PULSE: begin
               if (pcnt_q == PW'(WL_PULSE - 1)) begin
                  state_d = ST_HOLD;
                  pcnt_d  = '0;
               end else begin
                  pcnt_d = pcnt_q + 1'b1;
               end
            end
            ST_HOLD: begin
               bit_d = '0;
               if (row_q == RW'(WL_WIDTH - 1)) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_SHIFT;
                  row_d   = row_q + 1'b1;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
               row_d   = '0;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Outputs are derived from the next state so the registered copies line
   // up with state_q; the row's last bit is folded in on the SETUP entry edge.
   always_comb begin
      bl_d   = '0;
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
      if (state_d == ST_SETUP || state_d == ST_PULSE || state_d == ST_HOLD)
         bl_d = xfer ? shadow_nxt : shadow;
      for (int i = 0; i < WL_WIDTH; i++)
         wl_d[i] = (state_d == ST_PULSE) && (row_d == RW'(i));
   end

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
         bit_q   <= '0;
         pcnt_q  <= '0;
         bl_q    <= '0;
         wl_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         bit_q   <= bit_d;
         pcnt_q  <= pcnt_d;
         bl_q    <= bl_d;
         wl_q    <= wl_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bl   = bl_q;
   assign wl   = wl_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
